maze_step_unit: RTL and testbench



---
 rtl/maze_step_unit.sv | 164 ++++++++++++++++
 tb/tb_maze_step_unit.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/maze_step_unit.sv
// maze_step_unit: holds the walker's (X,Y) position and applies step requests
// after an external wall query. Every committed step is pushed onto a path
// stack so that back requests can retrace the path.
module maze_step_unit #(
    parameter int unsigned        COORD_W = 4,
    parameter int unsigned        DEPTH   = 16,
    parameter logic [COORD_W-1:0] GOAL_X  = '1,
    parameter logic [COORD_W-1:0] GOAL_Y  = '1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       init,
    input  logic [2*COORD_W-1:0]       init_loc,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_op,
    input  logic [1:0]                 req_dir,
    output logic                       q_valid,
    output logic [2*COORD_W-1:0]       q_loc,
    input  logic                       q_rsp_valid,
    input  logic                       q_wall,
    output logic                       rsp_valid,
    output logic [1:0]                 rsp_code,
    output logic [2*COORD_W-1:0]       loc,
    output logic [$clog2(DEPTH):0]     depth,
    output logic [15:0]                step_cnt,
    output logic                       at_goal
);

    localparam int unsigned LW = 2 * COORD_W;
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned DW = AW + 1;

    localparam logic [1:0] CODE_MOVED = 2'b00;
    localparam logic [1:0] CODE_EDGE  = 2'b01;
    localparam logic [1:0] CODE_WALL  = 2'b10;
    localparam logic [1:0] CODE_STACK = 2'b11;

    typedef enum logic [1:0] {IDLE, QUERY, DONE} stateT;

    stateT              state, nextState;
    logic [LW-1:0]      candReg;
    logic [1:0]         codeReg, nextCode;
    logic               loadCand, doPush, doPop, accept;
    logic [LW-1:0]      stackMem [DEPTH];

    logic [COORD_W-1:0] curX, curY, axisVal, newVal;
    logic               axisIsX, incDir, atEdge, stackFull, stackEmpty;
    logic [LW-1:0]      candNext;
    logic [DW-1:0]      depthDec;
    logic [15:0]        cntInc;

    assign curX       = loc[LW-1:COORD_W];
    assign curY       = loc[COORD_W-1:0];
    assign axisIsX    = ^req_dir;
    assign incDir     = req_dir[0];
    assign axisVal    = axisIsX ? curX : curY;
    assign atEdge     = incDir ? (axisVal == '1) : (axisVal == '0);
    assign newVal     = incDir ? axisVal + COORD_W'(1) : axisVal - COORD_W'(1);
    assign candNext   = axisIsX ? {newVal, curY} : {curX, newVal};
    assign stackFull  = (depth == DW'(DEPTH));
    assign stackEmpty = (depth == '0);
    assign depthDec   = depth - DW'(1);
    assign cntInc     = (step_cnt == '1) ? step_cnt : step_cnt + 16'd1;

    assign q_loc    = candReg;
    assign rsp_code = codeReg;
    assign at_goal  = (loc == {GOAL_X, GOAL_Y});

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= nextState;
    end

    // Next-state decode, handshake outputs and datapath strobes
    always_comb begin
        nextState = state;
        nextCode  = codeReg;
        loadCand  = 1'b0;
        doPush    = 1'b0;
        doPop     = 1'b0;
        req_ready = (state == IDLE) && !init;
        q_valid   = (state == QUERY);
        rsp_valid = (state == DONE);
        accept    = req_valid && req_ready;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (req_op) begin
                        nextState = DONE;
                        if (stackEmpty) begin
                            nextCode = CODE_STACK;
                        end else begin
                            nextCode = CODE_MOVED;
                            doPop    = 1'b1;
                        end
                    end else if (atEdge) begin
                        nextState = DONE;
                        nextCode  = CODE_EDGE;
                    end else if (stackFull) begin
                        nextState = DONE;
                        nextCode  = CODE_STACK;
                    end else begin
                        nextState = QUERY;
                        loadCand  = 1'b1;
                    end
                end
            end
            QUERY: begin
                if (q_rsp_valid) begin
                    nextState = DONE;
                    if (q_wall) begin
                        nextCode = CODE_WALL;
                    end else begin
                        nextCode = CODE_MOVED;
                        doPush   = 1'b1;
                    end
                end
            end
            default: nextState = IDLE;
        endcase
        // init aborts whatever is in flight without a response
        if (init) begin
            nextState = IDLE;
            doPush    = 1'b0;
            doPop     = 1'b0;
            loadCand  = 1'b0;
        end
    end

    // Location, occupancy, move counter, candidate and result code
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            loc      <= '0;
            depth    <= '0;
            step_cnt <= '0;
            candReg  <= '0;
            codeReg  <= '0;
        end else if (init) begin
            loc      <= init_loc;
            depth    <= '0;
            step_cnt <= '0;
        end else begin
            codeReg <= nextCode;
            if (loadCand) candReg <= candNext;
            if (doPush) begin
                loc      <= candReg;
                depth    <= depth + DW'(1);
                step_cnt <= cntInc;
            end else if (doPop) begin
                loc      <= stackMem[depthDec[AW-1:0]];
                depth    <= depthDec;
                step_cnt <= cntInc;
            end
        end
    end

    // Path stack storage; contents beyond depth are don't-care
    always_ff @(posedge clk) begin
        if (doPush) stackMem[depth[AW-1:0]] <= loc;
    end

endmodule

// File: tb/tb_maze_step_unit.sv
// Directed bench for maze_step_unit (DEPTH=4) with a coordinate/queue model.
module tb_maze_step_unit;

    localparam int CW = 4;
    localparam int DP = 4;

    logic          clk = 1'b0;
    logic          rst, init, req_valid, req_ready, req_op;
    logic [7:0]    init_loc, q_loc, loc;
    logic [1:0]    req_dir, rsp_code;
    logic          q_valid, q_rsp_valid, q_wall, rsp_valid, at_goal;
    logic [2:0]    depth;
    logic [15:0]   step_cnt;

    int vectors = 0;
    int miscompares = 0;

    // model: plain integer coordinates, a queue as the path stack, a move count
    int mx = 0, my = 0, mCnt = 0;
    int mStack[$];
    int seenQLoc, qHold;

    always #5 clk = ~clk;

    maze_step_unit #(.COORD_W(CW), .DEPTH(DP)) dut (
        .clk(clk), .rst(rst), .init(init), .init_loc(init_loc),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_dir(req_dir), .q_valid(q_valid), .q_loc(q_loc),
        .q_rsp_valid(q_rsp_valid), .q_wall(q_wall), .rsp_valid(rsp_valid),
        .rsp_code(rsp_code), .loc(loc), .depth(depth), .step_cnt(step_cnt),
        .at_goal(at_goal)
    );

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // architectural state checked against the model on every cycle
    always @(negedge clk) begin
        chk("loc", int'(loc), mx * 16 + my);
        chk("depth", int'(depth), mStack.size());
        chk("step_cnt", int'(step_cnt), mCnt);
        chk("at_goal", int'(at_goal), int'(mx == 15 && my == 15));
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic doInit(input int x, input int y);
        init = 1'b1; init_loc = 8'(x * 16 + y);
        req_valid = 1'b1; req_op = 1'b0; req_dir = 2'b01;
        @(negedge clk);
        chk("ready_in_init", int'(req_ready), 0);
        tick;
        init = 1'b0; req_valid = 1'b0;
        mx = x; my = y; mCnt = 0; mStack.delete();
        @(negedge clk);
        chk("init_no_rsp", int'(rsp_valid), 0);
        chk("init_no_query", int'(q_valid), 0);
        tick;
    endtask

    task automatic doStep(input logic [1:0] dir, input int waits, input bit wall);
        int cx, cy, code, qexp;
        cx = mx; cy = my;
        case (dir)
            2'd0: cy = cy - 1;
            2'd1: cx = cx + 1;
            2'd2: cx = cx - 1;
            default: cy = cy + 1;
        endcase
        qexp = cx * 16 + cy;
        if (cx < 0 || cx > 15 || cy < 0 || cy > 15) code = 1;
        else if (mStack.size() == DP) code = 3;
        else code = wall ? 2 : 0;
        qHold = 0;
        req_valid = 1'b1; req_op = 1'b0; req_dir = dir;
        @(negedge clk);
        chk("ready_before_step", int'(req_ready), 1);
        tick;
        req_valid = 1'b0;
        if (code == 1 || code == 3) begin
            @(negedge clk);
            chk("rsp_valid_t1", int'(rsp_valid), 1);
            chk("rsp_code", int'(rsp_code), code);
            chk("no_query", int'(q_valid), 0);
            tick;
            @(negedge clk);
            chk("rsp_pulse_end", int'(rsp_valid), 0);
            chk("no_query_t2", int'(q_valid), 0);
            chk("ready_t2", int'(req_ready), 1);
        end else begin
            for (int i = 0; i < waits; i++) begin
                @(negedge clk);
                chk("q_valid_wait", int'(q_valid), 1);
                chk("q_loc_wait", int'(q_loc), qexp);
                chk("no_rsp_wait", int'(rsp_valid), 0);
                chk("busy_wait", int'(req_ready), 0);
                qHold += int'(q_valid);
                tick;
            end
            q_rsp_valid = 1'b1; q_wall = wall;
            @(negedge clk);
            chk("q_valid", int'(q_valid), 1);
            chk("q_loc", int'(q_loc), qexp);
            seenQLoc = int'(q_loc);
            qHold += int'(q_valid);
            tick;
            q_rsp_valid = 1'b0; q_wall = 1'b0;
            if (!wall) begin
                mStack.push_back(mx * 16 + my);
                mx = cx; my = cy; mCnt++;
            end
            @(negedge clk);
            chk("rsp_valid_q", int'(rsp_valid), 1);
            chk("rsp_code_q", int'(rsp_code), code);
            chk("q_dropped", int'(q_valid), 0);
            tick;
            @(negedge clk);
            chk("rsp_pulse_end_q", int'(rsp_valid), 0);
            chk("ready_t3", int'(req_ready), 1);
        end
        tick;
    endtask

    task automatic doBack;
        int code, v;
        code = (mStack.size() == 0) ? 3 : 0;
        req_valid = 1'b1; req_op = 1'b1; req_dir = 2'b00;
        @(negedge clk);
        chk("ready_before_back", int'(req_ready), 1);
        tick;
        req_valid = 1'b0; req_op = 1'b0;
        if (code == 0) begin
            v = mStack.pop_back();
            mx = v / 16; my = v % 16; mCnt++;
        end
        @(negedge clk);
        chk("rsp_valid_back", int'(rsp_valid), 1);
        chk("rsp_code_back", int'(rsp_code), code);
        chk("no_query_back", int'(q_valid), 0);
        tick;
        @(negedge clk);
        chk("rsp_pulse_end_back", int'(rsp_valid), 0);
        chk("ready_after_back", int'(req_ready), 1);
        tick;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; init = 1'b0; init_loc = '0; req_valid = 1'b0; req_op = 1'b0;
        req_dir = '0; q_rsp_valid = 1'b0; q_wall = 1'b0;
        tick; tick;
        @(negedge clk);
        chk("rst_ready", int'(req_ready), 1);
        chk("rst_q_valid", int'(q_valid), 0);
        chk("rst_q_loc", int'(q_loc), 0);
        chk("rst_rsp_valid", int'(rsp_valid), 0);
        chk("rst_rsp_code", int'(rsp_code), 0);
        chk("rst_at_goal", int'(at_goal), 0);
        tick;
        rst = 1'b1;
        tick;

        // zero-wait legal step
        doInit(3, 5);
        doStep(2'd1, 0, 1'b0);
        chk("lit_loc_45", int'(loc), 8'h45);
        chk("lit_depth_1", int'(depth), 1);
        chk("lit_cnt_1", int'(step_cnt), 1);

        // edges on every side
        doInit(0, 7);  doStep(2'd2, 0, 1'b0);
        chk("lit_loc_07", int'(loc), 8'h07);
        doInit(15, 7); doStep(2'd1, 0, 1'b0);
        chk("lit_loc_f7", int'(loc), 8'hF7);
        doInit(3, 0);  doStep(2'd0, 0, 1'b0);
        chk("lit_loc_30", int'(loc), 8'h30);
        chk("lit_rsp_edge", int'(rsp_code), 1);

        // wall after three wait cycles
        doInit(2, 2);
        doStep(2'd3, 3, 1'b1);
        chk("lit_q_loc_23", seenQLoc, 8'h23);
        chk("lit_q_hold_4", qHold, 4);
        chk("lit_loc_22", int'(loc), 8'h22);
        chk("lit_depth_0", int'(depth), 0);
        chk("lit_rsp_wall", int'(rsp_code), 2);

        // answers outside QUERY are ignored
        q_rsp_valid = 1'b1; q_wall = 1'b0;
        tick; tick;
        @(negedge clk);
        chk("idle_rsp_ignored", int'(rsp_valid), 0);
        q_rsp_valid = 1'b0;
        tick;

        // three steps then backtrack
        doInit(5, 5);
        doStep(2'd1, 0, 1'b0);
        doStep(2'd3, 1, 1'b0);
        doStep(2'd2, 2, 1'b0);
        chk("lit_loc_56", int'(loc), 8'h56);
        doBack; chk("lit_back1", int'(loc), 8'h66);
        doBack; chk("lit_back2", int'(loc), 8'h65);
        doBack; chk("lit_back3", int'(loc), 8'h55);
        chk("lit_cnt_6", int'(step_cnt), 6);
        chk("lit_depth_back", int'(depth), 0);
        doBack;
        chk("lit_empty_code", int'(rsp_code), 3);
        chk("lit_loc_empty", int'(loc), 8'h55);

        // stack full
        doInit(1, 1);
        for (int i = 0; i < 4; i++) doStep(2'd1, 0, 1'b0);
        chk("lit_depth_4", int'(depth), 4);
        doStep(2'd3, 0, 1'b0);
        chk("lit_full_code", int'(rsp_code), 3);
        chk("lit_loc_51", int'(loc), 8'h51);

        // reach the goal corner, then hit its edge
        doInit(14, 14);
        doStep(2'd1, 0, 1'b0);
        doStep(2'd3, 1, 1'b0);
        chk("lit_at_goal", int'(at_goal), 1);
        doStep(2'd1, 0, 1'b0);

        // init while a query is pending
        doInit(7, 7);
        req_valid = 1'b1; req_op = 1'b0; req_dir = 2'b01;
        tick;
        req_valid = 1'b0;
        @(negedge clk);
        chk("query_pending", int'(q_valid), 1);
        tick;
        init = 1'b1; init_loc = 8'h9A; req_valid = 1'b1; q_rsp_valid = 1'b1; q_wall = 1'b0;
        @(negedge clk);
        chk("ready_init_query", int'(req_ready), 0);
        tick;
        init = 1'b0; req_valid = 1'b0; q_rsp_valid = 1'b0;
        mx = 9; my = 10; mCnt = 0; mStack.delete();
        @(negedge clk);
        chk("abort_no_rsp", int'(rsp_valid), 0);
        chk("abort_no_query", int'(q_valid), 0);
        chk("abort_ready", int'(req_ready), 1);
        chk("lit_loc_9a", int'(loc), 8'h9A);
        tick;
        @(negedge clk);
        chk("abort_no_rsp2", int'(rsp_valid), 0);
        tick;

        // reset while a query is pending
        doInit(4, 4);
        doStep(2'd1, 0, 1'b0);
        req_valid = 1'b1; req_op = 1'b0; req_dir = 2'b11;
        tick;
        req_valid = 1'b0;
        @(negedge clk);
        chk("query_pending2", int'(q_valid), 1);
        #2;
        rst = 1'b0;
        mx = 0; my = 0; mCnt = 0; mStack.delete();
        tick;
        @(negedge clk);
        chk("mid_rst_ready", int'(req_ready), 1);
        chk("mid_rst_q_valid", int'(q_valid), 0);
        chk("mid_rst_q_loc", int'(q_loc), 0);
        chk("mid_rst_rsp_valid", int'(rsp_valid), 0);
        chk("mid_rst_rsp_code", int'(rsp_code), 0);
        chk("mid_rst_loc", int'(loc), 0);
        tick;
        rst = 1'b1;
        tick;
        @(negedge clk);
        chk("post_rst_no_rsp", int'(rsp_valid), 0);
        tick;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
